// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature encoder conditioner: sync, debounce, Gray decode, one step per detent
// Outputs drive an up/down counter: dir -> x input, hold -> h input (0 = count).
module quad_step_decoder #(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int STEPS_PER_DETENT = 4,
    parameter int ERR_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    output logic             dir,
    output logic             hold,
    output logic             step,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [4:0] ACC_TOP = 5'(STEPS_PER_DETENT);

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0]        sync_m;
    logic [1:0]        sync_s;
    logic [1:0]        deb;
    logic [1:0]        prev;
    logic [CW-1:0]     db_cnt [2];
    logic [CW-1:0]     stable_cnt;
    logic              init;
    logic signed [4:0] accum;

    logic [1:0]        mv;
    logic              inc;
    logic              dec;
    logic              bad;
    logic signed [4:0] acc_nxt;
    logic              step_up;
    logic              step_dn;

    // Gray code to linear position: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m <= '0;
            sync_s <= '0;
        end else begin
            sync_m <= {a_in, b_in};
            sync_s <= sync_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb       <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_s[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    deb[i]    <= sync_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Decoding stays off until both channels have settled once after reset,
    // so whatever state the pins power up in is absorbed without an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init       <= 1'b1;
            stable_cnt <= '0;
        end else if (init) begin
            if (sync_s != deb) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                init <= 1'b0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        mv      = gray_pos(deb) - gray_pos(prev);
        inc     = 1'b0;
        dec     = 1'b0;
        bad     = 1'b0;
        if (!init) begin
            case (mv)
                2'd1:    inc = 1'b1;
                2'd3:    dec = 1'b1;
                2'd2:    bad = 1'b1;
                default: ;
            endcase
        end
        acc_nxt = accum;
        if (inc) begin
            acc_nxt = accum + 5'sd1;
        end else if (dec) begin
            acc_nxt = accum - 5'sd1;
        end
        step_up = (acc_nxt == ACC_TOP);
        step_dn = (acc_nxt == -ACC_TOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            accum   <= '0;
            dir     <= 1'b1;
            hold    <= 1'b1;
            step    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            prev <= deb;
            err  <= bad;
            step <= step_up | step_dn;
            hold <= ~(step_up | step_dn);
            if (step_up) begin
                dir <= 1'b1;
            end else if (step_dn) begin
                dir <= 1'b0;
            end
            if (bad || step_up || step_dn) begin
                accum <= '0;
            end else begin
                accum <= acc_nxt;
            end
            if (bad && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule
